// File: rtl/bpsk_pkg.sv
// Shared state encoding and default framing parameters for the BPSK frame controller.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  localparam int DEF_SPS       = 64;
  localparam int DEF_PRE_SYMS  = 8;
  localparam int DEF_GAP_SYMS  = 2;
  localparam int BITS_PER_BYTE = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bpsk_byte_buf.sv
// One-byte hold buffer in front of the frame FSM; in_ready is simply !hold_valid.
// A push lands one edge after the handshake; clr (abort) beats pop, which beats push.
module bpsk_byte_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       pop,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       hold_valid,
  output logic [7:0] hold_data,
  output logic       hold_last
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       push;

  assign push = in_valid && !valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (clr || pop) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = !valid_q;
  assign hold_valid = valid_q;
  assign hold_data  = data_q;
  assign hold_last  = last_q;

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// Frame sequencer driving a BPSK sine generator: preamble, MSB-first data bytes, silent gap.
// gen_en/gen_phase are registered and move only on symbol boundaries; input stalls only while the hold byte is full.
module bpsk_frame_ctrl
  import bpsk_pkg::*;
#(
  parameter int SPS      = DEF_SPS,
  parameter int PRE_SYMS = DEF_PRE_SYMS,
  parameter int GAP_SYMS = DEF_GAP_SYMS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       gen_en,
  output logic       gen_phase,
  output logic       gen_rst,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int CNT_W = $clog2(SPS);
  localparam int SYM_W = $clog2(max3(PRE_SYMS, GAP_SYMS, BITS_PER_BYTE));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [7:0]       sh_q, sh_d;
  logic             last_q, last_d;
  logic             gen_en_q, gen_en_d;
  logic             gen_phase_q, gen_phase_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  logic       active, kill, pop;
  logic       sym_end, pre_end, byte_end, gap_end;
  logic       hold_valid, hold_last;
  logic [7:0] hold_data;

  bpsk_byte_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (kill),
    .pop        (pop),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_last  (hold_last)
  );

  assign active   = (state_q != ST_IDLE);
  assign kill     = active && abort;
  assign sym_end  = (samp_q == CNT_W'(SPS - 1));
  assign pre_end  = sym_end && (sym_q == SYM_W'(PRE_SYMS - 1));
  assign byte_end = sym_end && (sym_q == SYM_W'(BITS_PER_BYTE - 1));
  assign gap_end  = sym_end && (sym_q == SYM_W'(GAP_SYMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      sym_q       <= '0;
      sh_q        <= '0;
      last_q      <= 1'b0;
      gen_en_q    <= 1'b0;
      gen_phase_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      sym_q       <= sym_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      gen_en_q    <= gen_en_d;
      gen_phase_q <= gen_phase_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    sym_d   = sym_q;
    sh_d    = sh_q;
    last_d  = last_q;
    pop     = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
      samp_d  = '0;
      sym_d   = '0;
    end else begin
      if (active) samp_d = sym_end ? '0 : samp_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          samp_d = '0;
          sym_d  = '0;
          if (start) state_d = ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (pre_end) begin
            sym_d = '0;
            if (hold_valid) begin
              state_d = ST_DATA;
              pop     = 1'b1;
              sh_d    = hold_data;
              last_d  = hold_last;
            end else begin
              state_d = ST_GAP;
            end
          end else if (sym_end) begin
            sym_d = sym_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (byte_end) begin
            sym_d = '0;
            // last is checked before hold_valid so a queued next-frame byte is left in the buffer
            if (!last_q && hold_valid) begin
              pop    = 1'b1;
              sh_d   = hold_data;
              last_d = hold_last;
            end else begin
              state_d = ST_GAP;
            end
          end else if (sym_end) begin
            sym_d = sym_q + 1'b1;
            sh_d  = sh_q << 1;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            sym_d   = '0;
            state_d = ST_IDLE;
          end else if (sym_end) begin
            sym_d = sym_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gen_en_d    = gen_en_q;
    gen_phase_d = gen_phase_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    if (kill) begin
      gen_en_d    = 1'b0;
      gen_phase_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            gen_en_d    = 1'b1;
            gen_phase_d = 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (pre_end) begin
            if (hold_valid) begin
              gen_phase_d = hold_data[7];
            end else begin
              gen_en_d    = 1'b0;
              gen_phase_d = 1'b0;
              underrun_d  = 1'b1;
            end
          end else if (sym_end) begin
            gen_phase_d = !gen_phase_q;
          end
        end
        ST_DATA: begin
          if (byte_end) begin
            if (!last_q && hold_valid) begin
              gen_phase_d = hold_data[7];
            end else begin
              gen_en_d    = 1'b0;
              gen_phase_d = 1'b0;
              underrun_d  = !last_q;
            end
          end else if (sym_end) begin
            gen_phase_d = sh_q[6];
          end
        end
        ST_GAP: begin
          if (gap_end) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gen_en    = gen_en_q;
  assign gen_phase = gen_phase_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign gen_rst   = !rst && !active && start;
  assign busy      = !rst && active;

endmodule

// File: doc/bpsk_frame_ctrl.md
BPSK_FRAME_CTRL -- requirements
Module: bpsk_frame_ctrl

Interface
REQ-001 SHALL have parameter SPS, default 64, giving samples per symbol; this equals the sine table depth.
REQ-002 SHALL have parameter PRE_SYMS, default 8, giving the number of preamble symbols.
REQ-003 SHALL have parameter GAP_SYMS, default 2, giving the number of silent trailer symbols.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: frame request, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1 bit: terminates the frame immediately.
REQ-008 SHALL have ports in_data (input, 8 bits), in_last (input, 1 bit), in_valid (input, 1 bit) and in_ready (output, 1 bit): byte stream with valid/ready handshake.
REQ-009 SHALL have port gen_en, output, 1 bit: enable to the sine generator.
REQ-010 SHALL have port gen_phase, output, 1 bit: phase to the sine generator (1 = index ascending).
REQ-011 SHALL have port gen_rst, output, 1 bit: one-cycle pulse that realigns the generator index to 0.
REQ-012 SHALL have ports busy, done and underrun, output, 1 bit each: status; done and underrun are one-cycle pulses.

Function
REQ-013 SHALL hold a one-byte buffer (data, last flag, valid); in_ready = !hold_valid, registered; a transfer occurs when in_valid and in_ready are both high at a clk edge, in any state.
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, DATA and GAP.
REQ-015 IDLE: when start=1, SHALL pulse gen_rst in that cycle and enter PREAMBLE in the next cycle; start in any other state is ignored.
REQ-016 SHALL keep a sample counter 0..SPS-1 that increments every cycle while in PREAMBLE, DATA or GAP; a symbol boundary is the cycle in which the counter equals SPS-1.
REQ-017 PREAMBLE: gen_en=1; gen_phase alternates per symbol starting at 1 (1,0,1,...); after PRE_SYMS symbols, SHALL go to DATA if hold_valid, else pulse underrun and go to GAP.
REQ-018 Entering DATA: SHALL load the shift register and last flag from the hold buffer and clear hold_valid in the same edge.
REQ-019 DATA: gen_en=1; gen_phase = the current bit, MSB first, 8 symbols per byte, each exactly SPS cycles.
REQ-020 DATA, byte boundary (8th symbol boundary):
  - if the current byte has last=1: SHALL go to GAP;
  - else if hold_valid: SHALL reload and continue with no idle cycle;
  - else: SHALL pulse underrun and go to GAP.
REQ-021 SHALL register an in_valid/in_ready transfer that coincides with a byte boundary into the buffer, and use it at the next boundary, not the current one.
REQ-022 GAP: gen_en=0 for GAP_SYMS*SPS cycles; SHALL then enter IDLE and pulse done in the first IDLE cycle.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL make gen_en and gen_phase registered outputs, changing only at symbol boundaries or state entry.
REQ-025 abort=1 in any non-IDLE state: SHALL enter IDLE next cycle with gen_en=0 and hold_valid cleared, with no done pulse; abort has priority over every other event.
REQ-026 SHALL allow bytes accepted in IDLE to preload the buffer; they remain valid for the next frame.
REQ-027 SHALL wrap the byte counter and sample counter to 0 at every boundary, with no overflow at any parameter value ≥ 2.

Reset
REQ-028 On rst=1, state SHALL be IDLE, all counters 0, and hold_valid 0.
REQ-029 During reset, SHALL drive gen_en=0, gen_phase=0, gen_rst=0, busy=0, done=0 and underrun=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset asserted mid-frame SHALL behave as abort and SHALL take priority over abort.

Structure
REQ-031 State encoding and the default SPS, PRE_SYMS and GAP_SYMS SHALL live in shared package bpsk_pkg.
REQ-032 The hold buffer SHALL be a sub-module, bpsk_byte_buf; the FSM and counters stay in bpsk_frame_ctrl.

Verification
REQ-033 Preload 0xA5 with last=1, then pulse start → 8 preamble symbols 1,0,1,0,1,0,1,0, data phases 1,0,1,0,0,1,0,1 (64 cycles each), 128 cycles gen_en=0, then done.
REQ-034 Stream 0xFF then 0x00 (last), with the second byte presented during the first byte → 16 data symbols with no gap and phase changing exactly at cycle 512 of DATA.
REQ-035 Start with an empty buffer → underrun pulse at the end of the preamble, then GAP and done.
REQ-036 Send byte 0x3C without last and no follow-up byte → underrun at the 8th data symbol boundary.
REQ-037 Assert abort in DATA at sample 17 → next cycle IDLE, gen_en=0, no done, in_ready=1.
REQ-038 Assert rst mid-PREAMBLE together with start → all outputs at reset values, and start ignored until rst is released.
